// File: rtl/uart_rx_multiformat.sv
// UART receiver with run-time 5-8 data bits, none/odd/even parity, 1/1.5/2 stop bits and a flagged RX FIFO.
// Define UART_RX_TIMEOUT_EN to add the idle receive-timeout register (addr 3) and STATUS[5].
module uart_rx_multiformat #(
  parameter int DBIT_MAX     = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int OVERSAMPLE   = 16,
  parameter int DVSR_WIDTH   = 11,
  parameter int DEFAULT_DVSR = 650
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  reg_addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic        rx,
  output logic        irq
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = DBIT_MAX + 2;
  localparam int S_W   = $clog2(2 * OVERSAMPLE) + 1;
  localparam int N_W   = $clog2(DBIT_MAX) + 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  logic                  ctrl_wr_s, stat_wr_s, pop_s, tick_s, rx_s, start_det_s;
  logic                  empty_s, full_s, wr_en_s, ferr_now_s;
  logic [N_W-1:0]        nbits_s, shift_s;
  logic [S_W-1:0]        stop_len_s;
  logic [DBIT_MAX-1:0]   data_just_s;
  logic [ENT_W-1:0]      head_s;
  logic                  to_st_s;
  logic [7:0]            to_thr_s;
  logic                  unused_s;

  logic [DVSR_WIDTH-1:0] dvsr_q;
  logic                  par_en_q, par_even_q;
  logic [1:0]            stop_q, dsel_q;
  logic [DVSR_WIDTH-1:0] bcnt_q;
  logic                  sync1_q, sync2_q, rx_prev_q;
  state_t                state_q;
  logic [S_W-1:0]        s_q;
  logic [N_W-1:0]        n_q;
  logic [DBIT_MAX-1:0]   b_q;
  logic                  perr_q, ferr_q, push_q;
  logic [ENT_W-1:0]      push_ent_q;
  logic [ENT_W-1:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  perr_st_q, ferr_st_q, ovr_st_q, irq_q;

  assign ctrl_wr_s   = cs & write & (reg_addr == 5'd0);
  assign stat_wr_s   = cs & write & (reg_addr == 5'd1);
  assign pop_s       = cs & read & (reg_addr == 5'd2) & ~empty_s;
  assign tick_s      = (bcnt_q == dvsr_q);
  assign rx_s        = sync2_q;
  assign start_det_s = (state_q == ST_IDLE) & tick_s & rx_prev_q & ~rx_s;
  assign empty_s     = (count_q == CNT_W'(0));
  assign full_s      = (count_q == CNT_W'(FIFO_DEPTH));
  assign wr_en_s     = push_q & (~full_s | pop_s);
  assign head_s      = mem_q[rd_ptr_q];
  assign nbits_s     = N_W'(8) - N_W'(dsel_q);
  assign shift_s     = N_W'(DBIT_MAX) - nbits_s;
  assign data_just_s = b_q >> shift_s;
  assign ferr_now_s  = (s_q == S_W'(OVERSAMPLE - 1)) ? ~rx_s : ferr_q;
  assign unused_s    = ^wr_data[31:17];
  assign irq         = irq_q;

  always_comb begin
    case (stop_q)
      2'b00:   stop_len_s = S_W'(OVERSAMPLE);
      2'b01:   stop_len_s = S_W'(OVERSAMPLE + OVERSAMPLE / 2);
      default: stop_len_s = S_W'(2 * OVERSAMPLE);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dvsr_q     <= DVSR_WIDTH'(DEFAULT_DVSR);
      par_en_q   <= 1'b0;
      par_even_q <= 1'b0;
      stop_q     <= 2'b00;
      dsel_q     <= 2'b00;
    end else if (ctrl_wr_s) begin
      dvsr_q     <= wr_data[DVSR_WIDTH-1:0];
      par_en_q   <= wr_data[11];
      par_even_q <= wr_data[12];
      stop_q     <= wr_data[14:13];
      dsel_q     <= wr_data[16:15];
    end
  end

  // Baud divider restarts on every CTRL write so new settings begin on a clean tick grid.
  always_ff @(posedge clk) begin
    if (reset || ctrl_wr_s || tick_s) begin
      bcnt_q <= '0;
    end else begin
      bcnt_q <= bcnt_q + DVSR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      if (tick_s) begin
        rx_prev_q <= rx_s;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      s_q        <= '0;
      n_q        <= '0;
      b_q        <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      push_q     <= 1'b0;
      push_ent_q <= '0;
    end else begin
      push_q <= 1'b0;
      if (ctrl_wr_s) begin
        state_q <= ST_IDLE;
        s_q     <= '0;
        n_q     <= '0;
      end else if (tick_s) begin
        case (state_q)
          ST_IDLE: begin
            if (start_det_s) begin
              state_q <= ST_START;
              s_q     <= '0;
            end
          end
          ST_START: begin
            if (s_q == S_W'(OVERSAMPLE / 2 - 1)) begin
              s_q <= '0;
              if (!rx_s) begin
                state_q <= ST_DATA;
                n_q     <= '0;
                b_q     <= '0;
                perr_q  <= 1'b0;
                ferr_q  <= 1'b0;
              end else begin
                state_q <= ST_IDLE;
              end
            end else begin
              s_q <= s_q + S_W'(1);
            end
          end
          ST_DATA: begin
            if (s_q == S_W'(OVERSAMPLE - 1)) begin
              s_q <= '0;
              b_q <= {rx_s, b_q[DBIT_MAX-1:1]};
              if (n_q == nbits_s - N_W'(1)) begin
                state_q <= par_en_q ? ST_PARITY : ST_STOP;
              end else begin
                n_q <= n_q + N_W'(1);
              end
            end else begin
              s_q <= s_q + S_W'(1);
            end
          end
          ST_PARITY: begin
            if (s_q == S_W'(OVERSAMPLE - 1)) begin
              s_q     <= '0;
              // Unused low bits of b_q are zero, so its reduction XOR is the data parity.
              perr_q  <= par_even_q ? (^b_q ^ rx_s) : ~(^b_q ^ rx_s);
              state_q <= ST_STOP;
            end else begin
              s_q <= s_q + S_W'(1);
            end
          end
          ST_STOP: begin
            if (s_q == S_W'(OVERSAMPLE - 1)) begin
              ferr_q <= ~rx_s;
            end
            if (s_q == stop_len_s - S_W'(1)) begin
              s_q        <= '0;
              state_q    <= ST_IDLE;
              push_q     <= 1'b1;
              push_ent_q <= {ferr_now_s, perr_q, data_just_s};
            end else begin
              s_q <= s_q + S_W'(1);
            end
          end
          default: begin
            state_q <= ST_IDLE;
            s_q     <= '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= push_ent_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({wr_en_s, pop_s})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky status: a set in the same cycle as a W1C wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      perr_st_q <= 1'b0;
      ferr_st_q <= 1'b0;
      ovr_st_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      perr_st_q <= (push_q & push_ent_q[DBIT_MAX])     | (perr_st_q & ~(stat_wr_s & wr_data[0]));
      ferr_st_q <= (push_q & push_ent_q[DBIT_MAX + 1]) | (ferr_st_q & ~(stat_wr_s & wr_data[1]));
      ovr_st_q  <= (push_q & full_s & ~pop_s)          | (ovr_st_q  & ~(stat_wr_s & wr_data[2]));
      irq_q     <= ~empty_s | perr_st_q | ferr_st_q | ovr_st_q | to_st_s;
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_W = 8 + $clog2(OVERSAMPLE) + 1;
  logic [7:0]      to_thr_q;
  logic [TO_W-1:0] to_cnt_q, to_target_s;
  logic            to_st_q, to_inc_s;

  assign to_target_s = TO_W'(to_thr_q) * TO_W'(OVERSAMPLE);
  assign to_inc_s    = tick_s & (state_q == ST_IDLE) & ~empty_s & (to_cnt_q < to_target_s);
  assign to_st_s     = to_st_q;
  assign to_thr_s    = to_thr_q;

  // The flag fires only on the increment that reaches the target, so a W1C sticks while the counter holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_thr_q <= 8'd0;
      to_cnt_q <= '0;
      to_st_q  <= 1'b0;
    end else begin
      if (cs && write && (reg_addr == 5'd3)) begin
        to_thr_q <= wr_data[7:0];
      end
      if (start_det_s || pop_s || ctrl_wr_s) begin
        to_cnt_q <= '0;
      end else if (to_inc_s) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end
      to_st_q <= (to_inc_s & (to_cnt_q + TO_W'(1) == to_target_s)) | (to_st_q & ~(stat_wr_s & wr_data[5]));
    end
  end
`else
  assign to_st_s  = 1'b0;
  assign to_thr_s = 8'd0;
`endif

  always_comb begin
    rd_data = 32'd0;
    case (reg_addr)
      5'd0: rd_data = 32'(dvsr_q) | {15'd0, dsel_q, stop_q, par_even_q, par_en_q, 11'd0};
      5'd1: rd_data = {16'd0, 8'(count_q), 2'd0, to_st_s, full_s, empty_s, ovr_st_q, ferr_st_q, perr_st_q};
      5'd2: rd_data = empty_s ? 32'h0000_0400
                              : {21'd0, 1'b0, head_s[DBIT_MAX + 1], head_s[DBIT_MAX], 8'(head_s[DBIT_MAX-1:0])};
      5'd3: rd_data = {24'd0, to_thr_s};
      default: rd_data = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_multiformat.sv
// Scoreboard bench for uart_rx_multiformat: serial frames in, expected READ words queued and popped on read.
`timescale 1ns/1ps
module tb_uart_rx_multiformat;
  localparam int OS       = 16;
  localparam int DVSR     = 3;
  localparam int BIT_CLKS = OS * (DVSR + 1);

  logic        clk = 1'b0;
  logic        reset, cs, read, write, rx;
  logic [4:0]  reg_addr;
  logic [31:0] wr_data, rd_data;
  logic        irq;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] v, e;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_multiformat #(
    .DBIT_MAX(8), .FIFO_DEPTH(4), .OVERSAMPLE(OS), .DVSR_WIDTH(11), .DEFAULT_DVSR(650)
  ) dut (
    .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
    .reg_addr(reg_addr), .wr_data(wr_data), .rd_data(rd_data), .rx(rx), .irq(irq)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task bus_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; write = 1'b1; reg_addr = a; wr_data = d;
    @(negedge clk);
    cs = 1'b0; write = 1'b0; wr_data = 32'd0;
  endtask

  task bus_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; read = 1'b1; reg_addr = a;
    #1 d = rd_data;
    @(negedge clk);
    cs = 1'b0; read = 1'b0;
  endtask

  task send_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task send_frame(input logic [7:0] d, input int nb, input logic pen, input logic pbit,
                  input logic stop_lvl, input int nstop);
    send_bit(1'b0);
    for (int i = 0; i < nb; i++) send_bit(d[i]);
    if (pen) send_bit(pbit);
    for (int i = 0; i < nstop; i++) send_bit(stop_lvl);
    rx = 1'b1;
  endtask

  task idle(input int bits);
    rx = 1'b1;
    repeat (bits * BIT_CLKS) @(negedge clk);
  endtask

  task test_reset;
    reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0; reg_addr = 5'd0; wr_data = 32'd0; rx = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    bus_read(5'd0, v); n_cmp++;
    if (v !== 32'h0000_028A) begin n_bad++; $display("FAIL reset_ctrl: got %h want %h", v, 32'h28A); end
    bus_read(5'd1, v); n_cmp++;
    if (v !== 32'h0000_0008) begin n_bad++; $display("FAIL reset_status: got %h want %h", v, 32'h8); end
    bus_read(5'd2, v); n_cmp++;
    if (v !== 32'h0000_0400) begin n_bad++; $display("FAIL reset_read: got %h want %h", v, 32'h400); end
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", irq); end
  endtask

  task test_8n2;
    bus_write(5'd0, 32'h0000_4003);
    idle(1);
    send_frame(8'h32, 8, 1'b0, 1'b0, 1'b1, 2);
    exp_q.push_back(32'h0000_0032);
    idle(1);
    bus_read(5'd1, v); n_cmp++;
    if (v[15:8] !== 8'd1) begin n_bad++; $display("FAIL 8n2_count: got %0d want 1", v[15:8]); end
    n_cmp++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL 8n2_irq_set: got %b want 1", irq); end
    bus_read(5'd2, v); e = exp_q.pop_front(); n_cmp++;
    if (v !== e) begin n_bad++; $display("FAIL 8n2_read: got %h want %h", v, e); end
    repeat (2) @(negedge clk);
    bus_read(5'd1, v); n_cmp++;
    if (v !== 32'h0000_0008) begin n_bad++; $display("FAIL 8n2_status_after: got %h want %h", v, 32'h8); end
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL 8n2_irq_clr: got %b want 0", irq); end
  endtask

  task test_parity;
    bus_write(5'd0, 32'h0001_9803);
    idle(1);
    send_frame(8'h15, 5, 1'b1, 1'b0, 1'b1, 1);
    exp_q.push_back(32'h0000_0115);
    idle(1);
    bus_read(5'd1, v); n_cmp++;
    if (v[0] !== 1'b1) begin n_bad++; $display("FAIL perr_sticky: got %b want 1", v[0]); end
    bus_read(5'd2, v); e = exp_q.pop_front(); n_cmp++;
    if (v !== e) begin n_bad++; $display("FAIL perr_read: got %h want %h", v, e); end
    bus_write(5'd1, 32'h0000_0001);
    repeat (2) @(negedge clk);
    bus_read(5'd1, v); n_cmp++;
    if (v !== 32'h0000_0008) begin n_bad++; $display("FAIL perr_w1c: got %h want %h", v, 32'h8); end
    bus_write(5'd0, 32'h0000_0803);
    idle(1);
    send_frame(8'h5A, 8, 1'b1, 1'b1, 1'b1, 1);
    exp_q.push_back(32'h0000_005A);
    idle(1);
    bus_read(5'd1, v); n_cmp++;
    if (v[1:0] !== 2'b00) begin n_bad++; $display("FAIL odd_ok_status: got %b want 00", v[1:0]); end
    bus_read(5'd2, v); e = exp_q.pop_front(); n_cmp++;
    if (v !== e) begin n_bad++; $display("FAIL odd_ok_read: got %h want %h", v, e); end
  endtask

  task test_frame_err;
    bus_write(5'd0, 32'h0000_9803);
    idle(1);
    send_frame(8'h41, 7, 1'b1, 1'b0, 1'b0, 1);
    exp_q.push_back(32'h0000_0241);
    idle(2);
    bus_read(5'd1, v); n_cmp++;
    if (v[1] !== 1'b1) begin n_bad++; $display("FAIL ferr_sticky: got %b want 1", v[1]); end
    bus_read(5'd2, v); e = exp_q.pop_front(); n_cmp++;
    if (v !== e) begin n_bad++; $display("FAIL ferr_read: got %h want %h", v, e); end
    bus_write(5'd1, 32'h0000_0002);
    repeat (2) @(negedge clk);
    bus_read(5'd1, v); n_cmp++;
    if (v !== 32'h0000_0008) begin n_bad++; $display("FAIL ferr_w1c: got %h want %h", v, 32'h8); end
  endtask

  task test_glitch_and_abort;
    bus_write(5'd0, 32'h0000_0003);
    idle(1);
    rx = 1'b0;
    repeat ((OS / 4) * (DVSR + 1)) @(negedge clk);
    idle(3);
    bus_read(5'd1, v); n_cmp++;
    if (v !== 32'h0000_0008) begin n_bad++; $display("FAIL glitch_status: got %h want %h", v, 32'h8); end
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL glitch_irq: got %b want 0", irq); end
    rx = 1'b0;
    repeat (3 * BIT_CLKS) @(negedge clk);
    bus_write(5'd0, 32'h0000_0003);
    repeat (BIT_CLKS) @(negedge clk);
    idle(12);
    bus_read(5'd1, v); n_cmp++;
    if (v !== 32'h0000_0008) begin n_bad++; $display("FAIL abort_status: got %h want %h", v, 32'h8); end
  endtask

  task test_back_to_back;
    logic [7:0] d;
    bus_write(5'd0, 32'h0000_0003);
    idle(1);
    for (int i = 1; i <= 5; i++) begin
      d = 8'(i);
      send_frame(d, 8, 1'b0, 1'b0, 1'b1, 1);
      if (i <= 4) exp_q.push_back({24'd0, d});
    end
    idle(1);
    bus_read(5'd1, v); n_cmp++;
    if (v !== 32'h0000_0414) begin n_bad++; $display("FAIL overrun_status: got %h want %h", v, 32'h414); end
    n_cmp++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL overrun_irq: got %b want 1", irq); end
    for (int i = 0; i < 4; i++) begin
      bus_read(5'd2, v); n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++; $display("FAIL b2b_read: got %h want <scoreboard empty>", v);
      end else begin
        e = exp_q.pop_front();
        if (v !== e) begin n_bad++; $display("FAIL b2b_read%0d: got %h want %h", i, v, e); end
      end
    end
    bus_read(5'd2, v); n_cmp++;
    if (v !== 32'h0000_0400) begin n_bad++; $display("FAIL b2b_drained: got %h want %h", v, 32'h400); end
    bus_write(5'd1, 32'h0000_0004);
    repeat (2) @(negedge clk);
    bus_read(5'd1, v); n_cmp++;
    if (v !== 32'h0000_0008) begin n_bad++; $display("FAIL overrun_w1c: got %h want %h", v, 32'h8); end
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL overrun_irq_clr: got %b want 0", irq); end
  endtask

  task test_timeout;
`ifdef UART_RX_TIMEOUT_EN
    bus_write(5'd3, 32'h0000_0004);
    idle(1);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1);
    exp_q.push_back(32'h0000_005A);
    repeat (40 * (DVSR + 1)) @(negedge clk);
    bus_read(5'd1, v); n_cmp++;
    if (v[5] !== 1'b0) begin n_bad++; $display("FAIL timeout_early: got %b want 0", v[5]); end
    repeat (40 * (DVSR + 1)) @(negedge clk);
    bus_read(5'd1, v); n_cmp++;
    if (v[5] !== 1'b1) begin n_bad++; $display("FAIL timeout_set: got %b want 1", v[5]); end
    bus_read(5'd2, v); e = exp_q.pop_front(); n_cmp++;
    if (v !== e) begin n_bad++; $display("FAIL timeout_read: got %h want %h", v, e); end
    bus_read(5'd1, v); n_cmp++;
    if (v[5] !== 1'b1) begin n_bad++; $display("FAIL timeout_hold: got %b want 1", v[5]); end
    bus_write(5'd1, 32'h0000_0020);
    repeat (2) @(negedge clk);
    bus_read(5'd1, v); n_cmp++;
    if (v !== 32'h0000_0008) begin n_bad++; $display("FAIL timeout_w1c: got %h want %h", v, 32'h8); end
`else
    bus_write(5'd3, 32'h0000_00FF);
    bus_read(5'd3, v); n_cmp++;
    if (v !== 32'h0000_0000) begin n_bad++; $display("FAIL timeout_absent_reg: got %h want 0", v); end
    bus_read(5'd1, v); n_cmp++;
    if (v[5] !== 1'b0) begin n_bad++; $display("FAIL timeout_absent_bit: got %b want 0", v[5]); end
`endif
  endtask

  initial begin
    test_reset();
    test_8n2();
    test_parity();
    test_frame_err();
    test_glitch_and_abort();
    test_back_to_back();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_multiformat.md
Name: uart_rx_multiformat

Overview:
- Parametrised successor receive core for the UART slot. Adds a run-time data width of 5–8 bits, 1/1.5/2 stop bits, and odd/even/no parity.
- Received words go into a parametrised FIFO. Each entry carries its own parity and frame error flags.
- Sticky parity/frame/overrun status bits, W1C, plus an interrupt output.
- Sits on the standard slot bus: cs/read/write, 5-bit reg_addr, 32-bit data.

Parameters:
- DBIT_MAX, 8: maximum data bits; FIFO entry width is DBIT_MAX+2.
- FIFO_DEPTH, 16: RX FIFO entries; power of 2, ≥2.
- OVERSAMPLE, 16: baud ticks per bit; even, ≥8.
- DVSR_WIDTH, 11: divisor width.
- DEFAULT_DVSR, 650: divisor after reset (9600 baud at 100 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cs  in  1  slot select.
- read  in  1  read strobe; pops READ register.
- write  in  1  write strobe.
- reg_addr  in  5  register index.
- wr_data  in  32  write data.
- rd_data  out  32  read data; combinational on reg_addr.
- rx  in  1  serial input, idle high, asynchronous.
- irq  out  1  level interrupt.

Behaviour:
Registers:
- Addr 0, CTRL (RW):
  - [10:0] dvsr.
  - [11] parity_en.
  - [12] parity_even.
  - [14:13] stop: 00=1, 01=1.5, 10=2, 11=2.
  - [16:15] data: 00=8, 01=7, 10=6, 11=5.
  - Reset value: DEFAULT_DVSR, all other fields 0.
- Addr 1, STATUS:
  - [0] parity_err, [1] frame_err, [2] overrun, [5] timeout: sticky, W1C.
  - [3] empty, [4] full.
  - [15:8] fifo count.
  - Other bits read 0.
- Addr 2, READ:
  - [DBIT_MAX-1:0] oldest data, zero-extended above the active width.
  - [8] entry parity err, [9] entry frame err, [10] empty.
  - When empty, reads 0x400.
  - cs&read at addr 2 pops on that clock edge; rd_data shows the pre-pop value in that cycle.
  - Pop when empty: no effect.
- Addr 3, TIMEOUT: see Optional Feature; otherwise reads 0, writes ignored.
- Other addresses: read 0.

Baud and input:
- Baud tick: counter 0..dvsr; one-cycle tick when count==dvsr. The counter restarts on any CTRL write.
- rx passes through a 2-flop synchroniser; both flops reset to 1.

Receive FSM (advances on ticks only):
- IDLE: falling edge on synchronised rx → START.
- START: at OVERSAMPLE/2 ticks, if rx is 0 → DATA; if rx is 1, treat as a glitch and return to IDLE with no push.
- DATA: sample every OVERSAMPLE ticks, LSB first, n bits (n from CTRL). Go to PARITY if parity_en, else STOP.
- PARITY: one sample after OVERSAMPLE ticks. Error if the bit is wrong:
  - even: total ones including the parity bit must be even;
  - odd: total must be odd.
- STOP: wait OVERSAMPLE, 1.5×OVERSAMPLE or 2×OVERSAMPLE ticks. Sample rx at the first OVERSAMPLE-tick point; 0 means frame error. At the end, push {ferr, perr, data} and go to IDLE.
- The data shift register is right-justified at push: shift right by DBIT_MAX−n.
- CTRL write mid-frame: FSM → IDLE, frame discarded, no push.

FIFO:
- Push when full and no pop in the same cycle: entry dropped, overrun set.
- Push and pop in the same cycle: both take effect; count unchanged, including when full.
- A push sets sticky parity_err / frame_err if the entry carries them.
- Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.

irq:
- irq = !empty | parity_err | frame_err | overrun | timeout. It is registered (one cycle after cause).

Reset:
- Any cycle, including mid-frame: FSM IDLE, FIFO empty, stickies 0, CTRL default, irq 0, baud counter 0.

Optional Feature:
- Macro: UART_RX_TIMEOUT_EN.
- Defined:
  - TIMEOUT register [7:0] threshold in bit periods; reset 0 disables.
  - Timeout counter runs in baud ticks while the FSM is IDLE and the FIFO is non-empty. It clears on a frame start, a pop, or a CTRL write.
  - On reaching threshold×OVERSAMPLE ticks, set STATUS[5]; that asserts irq.
  - The counter holds until cleared.
- Undefined: no counter logic; STATUS[5]=0, addr 3 reads 0.

Test Plan:
- Reset, then read CTRL/STATUS/READ → CTRL 0x28A, STATUS 0x8, READ 0x400; irq=0.
- dvsr=3, 8N2, send 0x32 → STATUS count 1, irq=1; READ 0x032 → then STATUS 0x8, irq=0.
- dvsr=3, 5 data bits, even parity, send data 0x15 with parity bit 0 → READ 0x115; STATUS[0]=1; write STATUS 0x1 → STATUS[0]=0.
- Frame-level cases:
  - 7E1 frame 0x41 with stop bit held 0 → READ 0x241, STATUS[1]=1.
  - rx low for OVERSAMPLE/4 ticks then high → no push, STATUS 0x8.
- FIFO_DEPTH=4, send 0x01..0x05 without reading → full, count 4, overrun=1; reads 0x001..0x004 then 0x400.
- With UART_RX_TIMEOUT_EN: TIMEOUT=4, one frame 0x5A, rx idle → STATUS[5]=1 exactly 64 ticks after STOP exit; pop clears the counter, but STATUS[5] stays until W1C.
